// File: rtl/rom_arbiter.sv
// Round-robin, burst-granular arbiter sharing one synchronous ROM macro
// between two word-addressed requesters with valid/ready response handshakes.
module rom_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [LEN_W-1:0]  p0_req_len,
  output logic              p0_resp_valid,
  input  logic              p0_resp_ready,
  output logic              p0_resp_last,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [LEN_W-1:0]  p1_req_len,
  output logic              p1_resp_valid,
  input  logic              p1_resp_ready,
  output logic              p1_resp_last,
  output logic [DATA_W-1:0] resp_data,
  input  logic [DATA_W-1:0] ROM_out_i,
  output logic              ROM_en_o,
  output logic              ROM_read_o,
  output logic [ADDR_W-1:0] ROM_addr_o,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, LOAD, DATA} state_t;

  state_t            r_state;
  logic              r_last1;
  logic              r_owner;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;

  logic w_idle;
  logic w_data;
  logic w_win0;
  logic w_win1;
  logic w_hs;
  logic w_last;

  // Grants are qualified by rst so no ready leaks out while reset is held.
  assign w_idle = (r_state == IDLE) & rst;
  assign w_data = (r_state == DATA);
  assign w_win0 = w_idle & p0_req_valid & (~p1_req_valid | r_last1);
  assign w_win1 = w_idle & p1_req_valid & (~p0_req_valid | ~r_last1);
  assign w_hs   = w_data & (r_owner ? p1_resp_ready : p0_resp_ready);
  assign w_last = (r_cnt == r_len);

  assign p0_req_ready  = w_win0;
  assign p1_req_ready  = w_win1;
  assign p0_resp_valid = w_data & ~r_owner;
  assign p1_resp_valid = w_data &  r_owner;
  assign p0_resp_last  = w_data & ~r_owner & w_last;
  assign p1_resp_last  = w_data &  r_owner & w_last;
  assign resp_data     = w_data ? ROM_out_i : '0;
  assign ROM_en_o      = (r_state == LOAD) | w_data;
  assign ROM_read_o    = (r_state == LOAD) | w_data;
  assign busy          = (r_state != IDLE);

  // Prefetching the next address on a handshake keeps beats back-to-back;
  // holding it on a stall keeps ROM_out_i stable.
  always_comb begin
    ROM_addr_o = '0;
    case (r_state)
      LOAD:    ROM_addr_o = r_base;
      DATA:    ROM_addr_o = w_hs ? r_cur_addr + ADDR_W'(1) : r_cur_addr;
      default: ROM_addr_o = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_last1    <= 1'b1;
      r_owner    <= 1'b0;
      r_base     <= '0;
      r_cur_addr <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_win0 | w_win1) begin
            r_owner    <= w_win1;
            r_base     <= w_win1 ? p1_req_addr : p0_req_addr;
            r_cur_addr <= w_win1 ? p1_req_addr : p0_req_addr;
            r_len      <= w_win1 ? p1_req_len : p0_req_len;
            r_cnt      <= '0;
            r_state    <= LOAD;
          end
        end
        LOAD: r_state <= DATA;
        DATA: begin
          if (w_hs) begin
            r_cur_addr <= r_cur_addr + ADDR_W'(1);
            r_cnt      <= r_cnt + LEN_W'(1);
            if (w_last) begin
              r_last1 <= r_owner;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed scenarios plus random traffic, checked every
// cycle against a burst-level reference model with a behavioural ROM.
module tb_rom_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_req_valid, p0_req_ready, p0_resp_valid, p0_resp_ready, p0_resp_last;
  logic        p1_req_valid, p1_req_ready, p1_resp_valid, p1_resp_ready, p1_resp_last;
  logic [11:0] p0_req_addr, p1_req_addr, ROM_addr_o;
  logic [3:0]  p0_req_len, p1_req_len;
  logic [31:0] resp_data, rom_q;
  logic        ROM_en_o, ROM_read_o, busy;

  rom_arbiter #(.ADDR_W(12), .DATA_W(32), .LEN_W(4)) dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
    .p0_req_addr(p0_req_addr), .p0_req_len(p0_req_len),
    .p0_resp_valid(p0_resp_valid), .p0_resp_ready(p0_resp_ready), .p0_resp_last(p0_resp_last),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
    .p1_req_addr(p1_req_addr), .p1_req_len(p1_req_len),
    .p1_resp_valid(p1_resp_valid), .p1_resp_ready(p1_resp_ready), .p1_resp_last(p1_resp_last),
    .resp_data(resp_data), .ROM_out_i(rom_q),
    .ROM_en_o(ROM_en_o), .ROM_read_o(ROM_read_o), .ROM_addr_o(ROM_addr_o), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] romf(input logic [11:0] a);
    return {a ^ 12'h5A3, 8'hC3, a};
  endfunction

  initial rom_q = '0;
  always @(posedge clk) if (ROM_en_o && ROM_read_o) rom_q <= romf(ROM_addr_o);

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected words of the current burst, owner, next address.
  logic [31:0] m_q[$];
  logic        m_owner = 1'b0;
  logic        m_last1 = 1'b1;
  bit          m_load = 1'b0;
  logic [11:0] m_addr = '0;
  logic [3:0]  m_len;
  bit          grant_log[$];
  int          nacc0 = 0, nacc1 = 0;
  logic        g0, g1, hs;

  always @(negedge clk) begin
    if (!rst) begin
      m_q.delete();
      m_load  = 1'b0;
      m_last1 = 1'b1;
    end else if (m_q.size() == 0) begin
      g0 = p0_req_valid && (!p1_req_valid || m_last1);
      g1 = p1_req_valid && (!p0_req_valid || !m_last1);
      chk("idle_busy", busy, 0);
      chk("idle_rdy", {p0_req_ready, p1_req_ready}, {g0, g1});
      chk("idle_resp", {p0_resp_valid, p1_resp_valid, p0_resp_last, p1_resp_last}, 0);
      chk("idle_rom", {ROM_en_o, ROM_read_o, ROM_addr_o}, 0);
      if (p0_req_valid && p0_req_ready) nacc0++;
      if (p1_req_valid && p1_req_ready) nacc1++;
      if (g0 || g1) begin
        m_owner = g1;
        m_addr  = g1 ? p1_req_addr : p0_req_addr;
        m_len   = g1 ? p1_req_len : p0_req_len;
        for (int i = 0; i <= int'(m_len); i++) m_q.push_back(romf(12'(m_addr + i)));
        m_load = 1'b1;
        grant_log.push_back(g1);
      end
    end else begin
      chk("busy", busy, 1);
      chk("wait_rdy", {p0_req_ready, p1_req_ready}, 0);
      if (m_load) begin
        chk("load_rom", {ROM_en_o, ROM_read_o, ROM_addr_o}, {2'b11, m_addr});
        chk("load_resp", {p0_resp_valid, p1_resp_valid}, 0);
        m_load = 1'b0;
      end else begin
        hs = m_owner ? p1_resp_ready : p0_resp_ready;
        chk("own_valid", {p0_resp_valid, p1_resp_valid}, m_owner ? 2'b01 : 2'b10);
        chk("data", resp_data, m_q[0]);
        chk("last", {p0_resp_last, p1_resp_last},
            (m_q.size() == 1) ? (m_owner ? 2'b01 : 2'b10) : 2'b00);
        chk("data_rom", {ROM_en_o, ROM_read_o, ROM_addr_o},
            {2'b11, hs ? 12'(m_addr + 12'd1) : m_addr});
        if (hs) begin
          void'(m_q.pop_front());
          m_addr = m_addr + 12'd1;
          if (m_q.size() == 0) m_last1 = m_owner;
        end
      end
    end
  end

  // Entered and left just after a rising edge; holds valid until accepted.
  task automatic req(input bit p, input logic [11:0] a, input logic [3:0] l);
    int n = 0;
    bit got;
    if (p) begin p1_req_addr = a; p1_req_len = l; p1_req_valid = 1'b1; end
    else   begin p0_req_addr = a; p0_req_len = l; p0_req_valid = 1'b1; end
    do begin
      @(negedge clk);
      n++;
      got = p ? (p1_req_valid && p1_req_ready) : (p0_req_valid && p0_req_ready);
    end while (!got && n < 300);
    chk(p ? "grant1" : "grant0", got, 1);
    @(posedge clk); #1;
    if (p) p1_req_valid = 1'b0; else p0_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (busy && n < 300);
    chk("idle_timeout", busy, 0);
  endtask

  task automatic chk_order(input string tag);
    chk({tag, "_n"}, grant_log.size(), 3);
    if (grant_log.size() == 3)
      chk(tag, {grant_log[0], grant_log[1], grant_log[2]}, 3'b010);
  endtask

  int seen0, seen1;

  initial begin
    {p0_req_valid, p1_req_valid, p0_req_addr, p1_req_addr, p0_req_len, p1_req_len} = '0;
    p0_resp_ready = 1'b1;
    p1_resp_ready = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("rst_ctl", {busy, p0_req_ready, p1_req_ready, p0_resp_valid, p1_resp_valid,
                    p0_resp_last, p1_resp_last, ROM_en_o, ROM_read_o}, 0);
    chk("rst_addr", ROM_addr_o, 0);
    @(posedge clk); #1 rst = 1'b1;

    req(0, 12'h010, 4'd3); wait_idle();
    req(1, 12'hFFE, 4'd3); wait_idle();

    // backpressure on beat 1 for three cycles
    req(0, 12'h345, 4'd2);
    @(posedge clk); #1;
    @(posedge clk); #1 p0_resp_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    p0_resp_ready = 1'b1;
    wait_idle();

    // tie after reset: 0, 1, 0
    rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    grant_log.delete();
    fork
      begin req(0, 12'h020, 4'd0); req(0, 12'h030, 4'd0); end
      req(1, 12'h040, 4'd0);
    join
    wait_idle();
    chk_order("tie_order");

    // port 1 raises during a port 0 burst while port 0 re-requests
    grant_log.delete();
    req(0, 12'h100, 4'd3);
    @(posedge clk); #1;
    fork
      req(1, 12'h200, 4'd1);
      req(0, 12'h300, 4'd0);
    join
    wait_idle();
    chk_order("cont_order");

    // reset during beat 2 of an 8-beat burst
    req(0, 12'h500, 4'd7);
    repeat (3) begin @(posedge clk); #1; end
    p1_req_addr = 12'h600; p1_req_len = 4'd2; p1_req_valid = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_ctl", {busy, p0_req_ready, p1_req_ready, p0_resp_valid, p1_resp_valid,
                        p0_resp_last, p1_resp_last, ROM_en_o, ROM_read_o}, 0);
    chk("mid_rst_out", {ROM_addr_o, resp_data}, 0);
    @(posedge clk); #1 rst = 1'b1;
    req(1, 12'h600, 4'd2);
    wait_idle();

    // random traffic
    seen0 = nacc0;
    seen1 = nacc1;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (nacc0 != seen0) begin seen0 = nacc0; p0_req_valid = 1'b0; end
      if (nacc1 != seen1) begin seen1 = nacc1; p1_req_valid = 1'b0; end
      if (c < 3700) begin
        if (!p0_req_valid && $urandom_range(0, 2) == 0) begin
          p0_req_addr = 12'($urandom); p0_req_len = 4'($urandom); p0_req_valid = 1'b1;
        end
        if (!p1_req_valid && $urandom_range(0, 2) == 0) begin
          p1_req_addr = 12'($urandom); p1_req_len = 4'($urandom); p1_req_valid = 1'b1;
        end
      end
      p0_resp_ready = ($urandom_range(0, 3) != 0);
      p1_resp_ready = ($urandom_range(0, 3) != 0);
    end
    p0_resp_ready = 1'b1;
    p1_resp_ready = 1'b1;
    wait_idle();
    chk("drained", {p0_req_valid, p1_req_valid}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
